// File: rtl/bram_stream_reader.sv
// Burst reader: turns a {start, length} command into credit-limited BRAM read requests and
// replays the in-order responses on a registered valid/ready stream.
// Optional: define BRAM_STREAM_READER_STALL_CTR_EN to add the STALL_CNT port and counter.
module bram_stream_reader #(
  parameter int addr_width = 10,
  parameter int data_width = 32,
  parameter int len_width  = 11,
  parameter int max_outst  = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [addr_width-1:0] CMD_START,
  input  logic [len_width-1:0]  CMD_LEN,
  input  logic                  CMD_EN,
  output logic                  CMD_RDY,
  output logic                  BUSY,
  output logic [addr_width-1:0] RD_ADDR,
  output logic                  RD_EN,
  input  logic                  RD_RDY,
  input  logic [data_width-1:0] DOUT,
  input  logic                  DOUT_RDY,
  output logic                  DOUT_EN,
  output logic [data_width-1:0] OUT_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  DONE
`ifdef BRAM_STREAM_READER_STALL_CTR_EN
  ,
  output logic [31:0]           STALL_CNT
`endif
);

  // Stream handshake: a word moves when OUT_VALID & OUT_READY on a rising edge; OUT_DATA is
  // held stable while OUT_VALID & ~OUT_READY. BUSY mirrors the FSM state (RUN).
  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                state_q, state_d;
  logic [addr_width-1:0] rd_addr_q, rd_addr_d;
  logic [len_width-1:0]  issued_q, issued_d;
  logic [len_width-1:0]  rcvd_q, rcvd_d;
  logic [len_width-1:0]  len_q, len_d;
  logic [data_width-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  done_q, done_d;

  logic                  run;
  logic [len_width-1:0]  outst;
  logic                  rd_en;
  logic                  dout_en;
  logic                  cmd_acc;
  logic                  last_acc;
  logic                  credit_ok;

  always_comb begin
    run       = (state_q == S_RUN);
    // issued - drained; DOUT_EN increments rcvd, so rcvd doubles as the drained count
    outst     = issued_q - rcvd_q;
    credit_ok = run && (issued_q < len_q) && (outst < len_width'(max_outst));
    rd_en     = credit_ok && RD_RDY;
    dout_en   = run && DOUT_RDY && (!out_valid_q || OUT_READY);
    cmd_acc   = !run && CMD_EN;
    last_acc  = run && out_valid_q && OUT_READY && (rcvd_q == len_q);
  end

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    issued_d    = issued_q;
    rcvd_d      = rcvd_q;
    len_d       = len_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;

    if (cmd_acc) begin
      rd_addr_d = CMD_START;
      issued_d  = '0;
      rcvd_d    = '0;
      len_d     = CMD_LEN;
      if (CMD_LEN != '0) state_d = S_RUN;
      else               done_d  = 1'b1;
    end

    if (rd_en) begin
      rd_addr_d = rd_addr_q + addr_width'(1);
      issued_d  = issued_q + len_width'(1);
    end

    if (dout_en) begin
      out_data_d  = DOUT;
      out_valid_d = 1'b1;
      rcvd_d      = rcvd_q + len_width'(1);
    end else if (OUT_READY) begin
      out_valid_d = 1'b0;
    end

    if (last_acc) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= '0;
      issued_q    <= '0;
      rcvd_q      <= '0;
      len_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      issued_q    <= issued_d;
      rcvd_q      <= rcvd_d;
      len_q       <= len_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign CMD_RDY   = !run;
  assign BUSY      = run;
  assign RD_ADDR   = rd_addr_q;
  assign RD_EN     = rd_en;
  assign DOUT_EN   = dout_en;
  assign OUT_DATA  = out_data_q;
  assign OUT_VALID = out_valid_q;
  assign DONE      = done_q;

`ifdef BRAM_STREAM_READER_STALL_CTR_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        stall;

  // A cycle counts once even if both the credit and the consumer stall at the same time
  always_comb begin
    stall       = (credit_ok && !RD_RDY) || (out_valid_q && !OUT_READY);
    stall_cnt_d = stall_cnt_q;
    if (cmd_acc)                             stall_cnt_d = '0;
    else if (stall && (stall_cnt_q != '1))   stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural BRAM (one-cycle read, response FIFO).
// Define BRAM_STREAM_READER_STALL_CTR_EN to also exercise the stall counter.
module tb_bram_stream_reader;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int LW = 11;
  localparam int MO = 2;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [AW-1:0] CMD_START = '0;
  logic [LW-1:0] CMD_LEN = '0;
  logic          CMD_EN = 1'b0;
  logic          CMD_RDY;
  logic          BUSY;
  logic [AW-1:0] RD_ADDR;
  logic          RD_EN;
  logic          RD_RDY = 1'b1;
  logic [DW-1:0] DOUT;
  logic          DOUT_RDY;
  logic          DOUT_EN;
  logic [DW-1:0] OUT_DATA;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b1;
  logic          DONE;
`ifdef BRAM_STREAM_READER_STALL_CTR_EN
  logic [31:0]   STALL_CNT;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  bram_stream_reader #(.addr_width(AW), .data_width(DW), .len_width(LW), .max_outst(MO)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .CMD_START(CMD_START), .CMD_LEN(CMD_LEN), .CMD_EN(CMD_EN), .CMD_RDY(CMD_RDY), .BUSY(BUSY),
    .RD_ADDR(RD_ADDR), .RD_EN(RD_EN), .RD_RDY(RD_RDY),
    .DOUT(DOUT), .DOUT_RDY(DOUT_RDY), .DOUT_EN(DOUT_EN),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .DONE(DONE)
`ifdef BRAM_STREAM_READER_STALL_CTR_EN
    , .STALL_CNT(STALL_CNT)
`endif
  );

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return 32'hC0DE_0000 + (32'(a) * 32'd7);
  endfunction

  // BRAM model: request accepted on RD_EN, response visible next cycle in a FIFO
  logic [DW-1:0] fifo [0:7];
  logic [2:0]    wp, rp;
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (RD_EN) begin
        fifo[wp] <= mem_word(RD_ADDR);
        wp <= wp + 3'd1;
      end
      if (DOUT_EN) rp <= rp + 3'd1;
    end
  end
  assign DOUT     = fifo[rp];
  assign DOUT_RDY = (wp != rp);

  // Monitor: stream words, request addresses, DONE pulses
  logic [DW-1:0] got_q[$];
  logic [AW-1:0] addr_q[$];
  int            acc_cyc_q[$];
  int            cyc = 0;
  int            done_cnt = 0;
  always @(posedge CLK) begin
    if (RST_N) begin
      cyc <= cyc + 1;
      if (OUT_VALID && OUT_READY) begin
        got_q.push_back(OUT_DATA);
        acc_cyc_q.push_back(cyc);
      end
      if (RD_EN) addr_q.push_back(RD_ADDR);
      if (DONE) done_cnt <= done_cnt + 1;
    end
  end

  logic [DW-1:0] exp_q[$];

  task automatic send_cmd(input logic [AW-1:0] start, input logic [LW-1:0] len);
    @(negedge CLK);
    CMD_START = start;
    CMD_LEN   = len;
    CMD_EN    = 1'b1;
    @(negedge CLK);
    CMD_EN    = 1'b0;
  endtask

  task automatic wait_done(input int base, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (done_cnt != base) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    n_total++;
    if ({CMD_RDY, BUSY, RD_EN, DOUT_EN, OUT_VALID, DONE} !== 6'b100000) begin
      $display("FAIL reset_flags got=%b want=100000", {CMD_RDY, BUSY, RD_EN, DOUT_EN, OUT_VALID, DONE});
    end else n_pass++;
    n_total++;
    if (RD_ADDR !== '0) $display("FAIL reset_rd_addr got=%h want=0", RD_ADDR);
    else n_pass++;
    n_total++;
    if (OUT_DATA !== '0) $display("FAIL reset_out_data got=%h want=0", OUT_DATA);
    else n_pass++;
  endtask

  // Burst with an always-ready consumer; checks data, back-to-back timing and a single DONE
  task automatic test_basic();
    int gb, db;
    bit ok;
    gb = got_q.size();
    db = done_cnt;
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(mem_word(AW'(10'h010 + k)));
    send_cmd(10'h010, 11'd4);
    wait_done(db, 50, ok);
    n_total++;
    if (!ok) $display("FAIL basic_timeout got=no_done want=done");
    else n_pass++;
    repeat (3) @(negedge CLK);
    n_total++;
    if (got_q.size() - gb !== 4) $display("FAIL basic_count got=%0d want=4", got_q.size() - gb);
    else n_pass++;
    for (int k = 0; k < 4 && gb + k < got_q.size(); k++) begin
      n_total++;
      if (got_q[gb + k] !== exp_q[k]) $display("FAIL basic_word%0d got=%h want=%h", k, got_q[gb + k], exp_q[k]);
      else n_pass++;
    end
    if (got_q.size() - gb >= 4) begin
      n_total++;
      if (acc_cyc_q[gb + 3] - acc_cyc_q[gb] !== 3)
        $display("FAIL basic_consecutive got=%0d want=3", acc_cyc_q[gb + 3] - acc_cyc_q[gb]);
      else n_pass++;
    end
    n_total++;
    if (done_cnt - db !== 1) $display("FAIL basic_done_count got=%0d want=1", done_cnt - db);
    else n_pass++;
    n_total++;
    if (CMD_RDY !== 1'b1) $display("FAIL basic_idle got=%b want=1", CMD_RDY);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int gb, ab, db;
    bit ok;
    logic [AW-1:0] exp_addr [4];
    exp_addr[0] = 10'h3FE; exp_addr[1] = 10'h3FF; exp_addr[2] = 10'h000; exp_addr[3] = 10'h001;
    gb = got_q.size();
    ab = addr_q.size();
    db = done_cnt;
    send_cmd(10'h3FE, 11'd4);
    wait_done(db, 50, ok);
    n_total++;
    if (!ok) $display("FAIL wrap_timeout got=no_done want=done");
    else n_pass++;
    n_total++;
    if (addr_q.size() - ab !== 4) $display("FAIL wrap_req_count got=%0d want=4", addr_q.size() - ab);
    else n_pass++;
    for (int k = 0; k < 4 && ab + k < addr_q.size(); k++) begin
      n_total++;
      if (addr_q[ab + k] !== exp_addr[k]) $display("FAIL wrap_addr%0d got=%h want=%h", k, addr_q[ab + k], exp_addr[k]);
      else n_pass++;
    end
    for (int k = 0; k < 4 && gb + k < got_q.size(); k++) begin
      n_total++;
      if (got_q[gb + k] !== mem_word(exp_addr[k]))
        $display("FAIL wrap_word%0d got=%h want=%h", k, got_q[gb + k], mem_word(exp_addr[k]));
      else n_pass++;
    end
  endtask

  // Consumer stalls for 5 cycles mid-burst
  task automatic test_backpressure();
    int gb, db, occ, max_occ;
    bit ok;
    logic [DW-1:0] held;
    gb = got_q.size();
    db = done_cnt;
    max_occ = 0;
    exp_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back(mem_word(AW'(10'h100 + k)));
    send_cmd(10'h100, 11'd8);
    for (int i = 0; i < 20 && got_q.size() - gb < 2; i++) @(negedge CLK);
    OUT_READY = 1'b0;
    held = OUT_DATA;
    n_total++;
    if (OUT_VALID !== 1'b1) $display("FAIL bp_valid_at_stall got=%b want=1", OUT_VALID);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      occ = int'(wp - rp) + int'(OUT_VALID);
      if (occ > max_occ) max_occ = occ;
      n_total++;
      if ({OUT_VALID, OUT_DATA} !== {1'b1, held})
        $display("FAIL bp_hold%0d got=%b/%h want=1/%h", i, OUT_VALID, OUT_DATA, held);
      else n_pass++;
    end
    OUT_READY = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      occ = int'(wp - rp) + int'(OUT_VALID);
      if (occ > max_occ) max_occ = occ;
      if (done_cnt != db) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    n_total++;
    if (!ok) $display("FAIL bp_timeout got=no_done want=done");
    else n_pass++;
    n_total++;
    if (max_occ > MO + 1) $display("FAIL bp_in_flight got=%0d want<=%0d", max_occ, MO + 1);
    else n_pass++;
    n_total++;
    if (got_q.size() - gb !== 8) $display("FAIL bp_count got=%0d want=8", got_q.size() - gb);
    else n_pass++;
    for (int k = 0; k < 8 && gb + k < got_q.size(); k++) begin
      n_total++;
      if (got_q[gb + k] !== exp_q[k]) $display("FAIL bp_word%0d got=%h want=%h", k, got_q[gb + k], exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_len_zero_and_busy_cmd();
    int gb, ab, db;
    bit ok;
    ab = addr_q.size();
    db = done_cnt;
    send_cmd(10'h055, 11'd0);
    n_total++;
    if ({DONE, CMD_RDY} !== 2'b11) $display("FAIL len0_done got=%b want=11", {DONE, CMD_RDY});
    else n_pass++;
    @(negedge CLK);
    n_total++;
    if (DONE !== 1'b0) $display("FAIL len0_done_pulse got=%b want=0", DONE);
    else n_pass++;
    repeat (3) @(negedge CLK);
    n_total++;
    if (addr_q.size() - ab !== 0) $display("FAIL len0_no_reads got=%0d want=0", addr_q.size() - ab);
    else n_pass++;

    gb = got_q.size();
    ab = addr_q.size();
    db = done_cnt;
    OUT_READY = 1'b0;
    send_cmd(10'h020, 11'd3);
    CMD_START = 10'h200;
    CMD_LEN   = 11'd5;
    CMD_EN    = 1'b1;
    n_total++;
    if (CMD_RDY !== 1'b0) $display("FAIL busy_cmd_rdy got=%b want=0", CMD_RDY);
    else n_pass++;
    repeat (2) @(negedge CLK);
    CMD_EN    = 1'b0;
    OUT_READY = 1'b1;
    wait_done(db, 50, ok);
    repeat (3) @(negedge CLK);
    n_total++;
    if (!ok) $display("FAIL busy_timeout got=no_done want=done");
    else n_pass++;
    n_total++;
    if ((got_q.size() - gb !== 3) || (addr_q.size() - ab !== 3))
      $display("FAIL busy_ignored got=%0d/%0d want=3/3", got_q.size() - gb, addr_q.size() - ab);
    else n_pass++;
    for (int k = 0; k < 3 && gb + k < got_q.size(); k++) begin
      n_total++;
      if (got_q[gb + k] !== mem_word(AW'(10'h020 + k)))
        $display("FAIL busy_word%0d got=%h want=%h", k, got_q[gb + k], mem_word(AW'(10'h020 + k)));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_burst();
    send_cmd(10'h080, 11'd8);
    @(negedge CLK);
    n_total++;
    if (BUSY !== 1'b1) $display("FAIL midrst_busy_before got=%b want=1", BUSY);
    else n_pass++;
    RST_N = 1'b0;
    #1;
    n_total++;
    if ({CMD_RDY, BUSY, RD_EN, DOUT_EN, OUT_VALID, DONE, RD_ADDR, OUT_DATA} !== {6'b100000, 10'h0, 32'h0})
      $display("FAIL midrst_outputs got=%b/%h/%h want=100000/0/0",
               {CMD_RDY, BUSY, RD_EN, DOUT_EN, OUT_VALID, DONE}, RD_ADDR, OUT_DATA);
    else n_pass++;
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    n_total++;
    if ({CMD_RDY, BUSY, RD_EN} !== 3'b100) $display("FAIL midrst_idle got=%b want=100", {CMD_RDY, BUSY, RD_EN});
    else n_pass++;
  endtask

`ifdef BRAM_STREAM_READER_STALL_CTR_EN
  task automatic test_stall_ctr();
    int gb, db;
    bit ok;
    gb = got_q.size();
    db = done_cnt;
    RD_RDY = 1'b1;
    send_cmd(10'h040, 11'd8);
    for (int i = 0; i < 20 && got_q.size() - gb < 2; i++) @(negedge CLK);
    OUT_READY = 1'b0;
    repeat (7) @(negedge CLK);
    OUT_READY = 1'b1;
    wait_done(db, 60, ok);
    @(negedge CLK);
    n_total++;
    if (!ok) $display("FAIL stall_timeout got=no_done want=done");
    else n_pass++;
    n_total++;
    if (STALL_CNT !== 32'd7) $display("FAIL stall_cnt got=%0d want=7", STALL_CNT);
    else n_pass++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout got=hung want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len_zero_and_busy_cmd();
    test_reset_mid_burst();
`ifdef BRAM_STREAM_READER_STALL_CTR_EN
    test_stall_ctr();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
